// File: rtl/plane_pkg.sv
// plane_pkg: shared types and default constants for the plane-equation stepper.
//   coef_t  : signed fixed-point coefficient/result at the default width
//   coord_t : unsigned pixel coordinate at the default width
//   state_t : stepper control states
package plane_pkg;

  localparam int unsigned DEF_TILE_W   = 2;
  localparam int unsigned DEF_TILE_H   = 2;
  localparam int unsigned DEF_CHANNELS = 1;
  localparam int unsigned DEF_COORD_W  = 16;
  localparam int unsigned DEF_COEF_W   = 24;
  localparam int unsigned DEF_FRAC     = 8;

  typedef logic signed [DEF_COEF_W-1:0] coef_t;
  typedef logic [DEF_COORD_W-1:0]       coord_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    EMIT  = 2'd2
  } state_t;

endpackage

// File: rtl/plane_tile_expand.sv
// plane_tile_expand: one channel of the stepper. Holds the per-pixel offsets
// (i*a + j*b), the tile steps, the current row base and the current tile
// base, and presents the TILE_H x TILE_W block of plane values.
//   clk, rst      : clock, asynchronous active-low reset
//   load          : compute row base, offsets and steps from a/b/c and box origin
//   adv_x         : move one tile right (cur += step_x)
//   adv_y         : move to the start of the next tile row
//   a, b, c       : plane coefficients (two's complement, wrap arithmetic)
//   x_min, y_min  : bounding box origin
//   z             : z[j][i] = cur + offset[j][i], packed j-major, i-minor
module plane_tile_expand
  import plane_pkg::*;
#(
  parameter int unsigned TILE_W  = DEF_TILE_W,
  parameter int unsigned TILE_H  = DEF_TILE_H,
  parameter int unsigned COORD_W = DEF_COORD_W,
  parameter int unsigned COEF_W  = DEF_COEF_W
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load,
  input  logic                              adv_x,
  input  logic                              adv_y,
  input  logic [COEF_W-1:0]                 a,
  input  logic [COEF_W-1:0]                 b,
  input  logic [COEF_W-1:0]                 c,
  input  logic [COORD_W-1:0]                x_min,
  input  logic [COORD_W-1:0]                y_min,
  output logic [TILE_H*TILE_W*COEF_W-1:0]   z
);

  logic [COEF_W-1:0] offset [TILE_H][TILE_W];
  logic [COEF_W-1:0] step_x;
  logic [COEF_W-1:0] step_y;
  logic [COEF_W-1:0] row_base;
  logic [COEF_W-1:0] cur;
  logic [COEF_W-1:0] origin;

  // The low COEF_W bits of a product do not depend on operand signedness,
  // so a truncated unsigned multiply gives the signed*unsigned result mod 2^COEF_W.
  function automatic logic [COEF_W-1:0] mul_trunc(input logic [COEF_W-1:0] v,
                                                  input logic [COEF_W-1:0] k);
    return v * k;
  endfunction

  assign origin = c + mul_trunc(a, COEF_W'(x_min)) + mul_trunc(b, COEF_W'(y_min));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_x   <= '0;
      step_y   <= '0;
      row_base <= '0;
      cur      <= '0;
      for (int unsigned j = 0; j < TILE_H; j++) begin
        for (int unsigned i = 0; i < TILE_W; i++) begin
          offset[j][i] <= '0;
        end
      end
    end else if (load) begin
      row_base <= origin;
      cur      <= origin;
      step_x   <= mul_trunc(a, COEF_W'(TILE_W));
      step_y   <= mul_trunc(b, COEF_W'(TILE_H));
      for (int unsigned j = 0; j < TILE_H; j++) begin
        for (int unsigned i = 0; i < TILE_W; i++) begin
          offset[j][i] <= mul_trunc(a, COEF_W'(i)) + mul_trunc(b, COEF_W'(j));
        end
      end
    end else if (adv_y) begin
      row_base <= row_base + step_y;
      cur      <= row_base + step_y;
    end else if (adv_x) begin
      cur <= cur + step_x;
    end
  end

  always_comb begin
    z = '0;
    for (int unsigned j = 0; j < TILE_H; j++) begin
      for (int unsigned i = 0; i < TILE_W; i++) begin
        z[(j*TILE_W+i)*COEF_W +: COEF_W] = cur + offset[j][i];
      end
    end
  end

endmodule

// File: rtl/plane_eq_stepper.sv
// plane_eq_stepper: walks a primitive's inclusive bounding box in raster-order
// tiles and emits z = c + a*x + b*y for every pixel of each tile, per channel.
//   clk, rst                    : clock, asynchronous active-low reset
//   in_valid / in_ready         : primitive setup handshake
//   in_a, in_b, in_c            : per-channel dz/dx, dz/dy, z(0,0)
//   in_x_min .. in_y_max        : inclusive bounding box
//   out_valid / out_ready       : tile handshake (outputs held under backpressure)
//   out_x, out_y                : tile origin
//   out_z                       : z[ch][j][i] at (out_x+i, out_y+j)
//   out_last                    : final tile of the primitive
module plane_eq_stepper
  import plane_pkg::*;
#(
  parameter int unsigned TILE_W   = DEF_TILE_W,
  parameter int unsigned TILE_H   = DEF_TILE_H,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  parameter int unsigned COORD_W  = DEF_COORD_W,
  parameter int unsigned COEF_W   = DEF_COEF_W,
  parameter int unsigned FRAC     = DEF_FRAC
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [CHANNELS*COEF_W-1:0]             in_a,
  input  logic [CHANNELS*COEF_W-1:0]             in_b,
  input  logic [CHANNELS*COEF_W-1:0]             in_c,
  input  logic [COORD_W-1:0]                     in_x_min,
  input  logic [COORD_W-1:0]                     in_y_min,
  input  logic [COORD_W-1:0]                     in_x_max,
  input  logic [COORD_W-1:0]                     in_y_max,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [COORD_W-1:0]                     out_x,
  output logic [COORD_W-1:0]                     out_y,
  output logic [CHANNELS*TILE_H*TILE_W*COEF_W-1:0] out_z,
  output logic                                   out_last
);

  localparam int unsigned ZW = TILE_H * TILE_W * COEF_W;

  if (FRAC >= COEF_W) begin : g_frac_chk
    $error("FRAC must be smaller than COEF_W");
  end

  state_t state, state_next;

  logic [CHANNELS*COEF_W-1:0] a_q, b_q, c_q;
  logic [COORD_W-1:0]         x_min_q, y_min_q, x_max_q, y_max_q;

  logic accept, load, adv_x, adv_y;
  logic x_end, y_end, empty;

  // One extra bit so a box touching 2^COORD_W-1 still ends instead of wrapping.
  assign x_end = ({1'b0, out_x} + (COORD_W+1)'(TILE_W)) > {1'b0, x_max_q};
  assign y_end = ({1'b0, out_y} + (COORD_W+1)'(TILE_H)) > {1'b0, y_max_q};
  assign empty = (x_min_q > x_max_q) || (y_min_q > y_max_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    out_last   = 1'b0;
    accept     = 1'b0;
    load       = 1'b0;
    adv_x      = 1'b0;
    adv_y      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid && rst) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        if (empty) begin
          state_next = IDLE;
        end else begin
          load       = 1'b1;
          state_next = EMIT;
        end
      end
      EMIT: begin
        out_valid = 1'b1;
        out_last  = x_end && y_end;
        if (out_ready) begin
          if (out_last) begin
            state_next = IDLE;
          end else if (x_end) begin
            adv_y = 1'b1;
          end else begin
            adv_x = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      x_min_q <= '0;
      y_min_q <= '0;
      x_max_q <= '0;
      y_max_q <= '0;
      out_x   <= '0;
      out_y   <= '0;
    end else begin
      if (accept) begin
        a_q     <= in_a;
        b_q     <= in_b;
        c_q     <= in_c;
        x_min_q <= in_x_min;
        y_min_q <= in_y_min;
        x_max_q <= in_x_max;
        y_max_q <= in_y_max;
      end
      if (load) begin
        out_x <= x_min_q;
        out_y <= y_min_q;
      end else if (adv_y) begin
        out_x <= x_min_q;
        out_y <= out_y + COORD_W'(TILE_H);
      end else if (adv_x) begin
        out_x <= out_x + COORD_W'(TILE_W);
      end
    end
  end

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    plane_tile_expand #(
      .TILE_W (TILE_W),
      .TILE_H (TILE_H),
      .COORD_W(COORD_W),
      .COEF_W (COEF_W)
    ) u_expand (
      .clk  (clk),
      .rst  (rst),
      .load (load),
      .adv_x(adv_x),
      .adv_y(adv_y),
      .a    (a_q[ch*COEF_W +: COEF_W]),
      .b    (b_q[ch*COEF_W +: COEF_W]),
      .c    (c_q[ch*COEF_W +: COEF_W]),
      .x_min(x_min_q),
      .y_min(y_min_q),
      .z    (out_z[ch*ZW +: ZW])
    );
  end

endmodule

// File: tb/tb_plane_eq_stepper.sv
// Directed bench for plane_eq_stepper at default parameters (2x2 tiles,
// one channel, 16-bit coordinates, 24-bit coefficients).
module tb_plane_eq_stepper;

  localparam int unsigned TW = 2;
  localparam int unsigned TH = 2;
  localparam int unsigned CH = 1;
  localparam int unsigned CW = 16;
  localparam int unsigned KW = 24;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CH*KW-1:0]  in_a = '0, in_b = '0, in_c = '0;
  logic [CW-1:0]     in_x_min = '0, in_y_min = '0, in_x_max = '0, in_y_max = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [CW-1:0]     out_x, out_y;
  logic [CH*TH*TW*KW-1:0] out_z;
  logic              out_last;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  plane_eq_stepper #(
    .TILE_W(TW), .TILE_H(TH), .CHANNELS(CH), .COORD_W(CW), .COEF_W(KW), .FRAC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .in_x_min(in_x_min), .in_y_min(in_y_min), .in_x_max(in_x_max), .in_y_max(in_y_max),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_x(out_x), .out_y(out_y), .out_z(out_z), .out_last(out_last)
  );

  function automatic logic [KW-1:0] zv(input int unsigned j, input int unsigned i);
    return out_z[(j*TW+i)*KW +: KW];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Presents a primitive and returns just after the accepting edge (T).
  task automatic send(input logic [KW-1:0] a, input logic [KW-1:0] b, input logic [KW-1:0] c,
                      input logic [CW-1:0] x0, input logic [CW-1:0] y0,
                      input logic [CW-1:0] x1, input logic [CW-1:0] y1);
    int unsigned n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("send_in_ready", 32'(in_ready), 32'd1);
    in_a = a; in_b = b; in_c = c;
    in_x_min = x0; in_y_min = y0; in_x_max = x1; in_y_max = y1;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Checks the SETUP cycle then the first EMIT cycle (valid at T+2).
  task automatic expect_first(input string tag);
    @(negedge clk);
    check({tag, "_setup_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_setup_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    check({tag, "_first_valid"}, 32'(out_valid), 32'd1);
  endtask

  // Checks the presented tile at a negedge, then lets it be consumed.
  task automatic tile(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y,
                      input logic [KW-1:0] z00, input logic [KW-1:0] z01,
                      input logic [KW-1:0] z10, input logic [KW-1:0] z11, input logic last);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_x"}, 32'(out_x), 32'(x));
    check({tag, "_y"}, 32'(out_y), 32'(y));
    check({tag, "_z00"}, 32'(zv(0, 0)), 32'(z00));
    check({tag, "_z01"}, 32'(zv(0, 1)), 32'(z01));
    check({tag, "_z10"}, 32'(zv(1, 0)), 32'(z10));
    check({tag, "_z11"}, 32'(zv(1, 1)), 32'(z11));
    check({tag, "_last"}, 32'(out_last), 32'(last));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    @(negedge clk);
  endtask

  task automatic expect_idle(input string tag);
    check({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_x", 32'(out_x), 32'd0);
    check("rst_y", 32'(out_y), 32'd0);
    check("rst_z", 32'(out_z), 32'd0);
    #5 rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Basic 2x2
    send(24'h000100, 24'h000200, 24'h000000, 16'd0, 16'd0, 16'd3, 16'd1);
    expect_first("basic");
    tile("basic_t0", 16'd0, 16'd0, 24'h000, 24'h100, 24'h200, 24'h300, 1'b0);
    tile("basic_t1", 16'd2, 16'd0, 24'h200, 24'h300, 24'h400, 24'h500, 1'b1);
    expect_idle("basic");

    // Row wrap
    send(24'h000000, 24'h000100, 24'h000080, 16'd4, 16'd6, 16'd5, 16'd9);
    expect_first("wrap");
    tile("wrap_t0", 16'd4, 16'd6, 24'h680, 24'h680, 24'h780, 24'h780, 1'b0);
    tile("wrap_t1", 16'd4, 16'd8, 24'h880, 24'h880, 24'h980, 24'h980, 1'b1);
    expect_idle("wrap");

    // Backpressure on first tile, with in_valid waved during EMIT
    out_ready = 1'b0;
    send(24'h000010, 24'h000020, 24'h001000, 16'd0, 16'd0, 16'd5, 16'd1);
    expect_first("bp");
    in_a = 24'h00ABCD; in_x_min = 16'd9; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_x", 32'(out_x), 32'd0);
      check("bp_hold_z00", 32'(zv(0, 0)), 32'h1000);
      check("bp_hold_z11", 32'(zv(1, 1)), 32'h1030);
      check("bp_hold_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tile("bp_t0", 16'd0, 16'd0, 24'h1000, 24'h1010, 24'h1020, 24'h1030, 1'b0);
    tile("bp_t1", 16'd2, 16'd0, 24'h1020, 24'h1030, 24'h1040, 24'h1050, 1'b0);
    tile("bp_t2", 16'd4, 16'd0, 24'h1040, 24'h1050, 24'h1060, 24'h1070, 1'b1);
    expect_idle("bp");

    // Negative coefficient and signed wrap
    send(24'hFFFF00, 24'h000000, 24'h000000, 16'd0, 16'd0, 16'd1, 16'd0);
    expect_first("neg");
    tile("neg_t0", 16'd0, 16'd0, 24'h000000, 24'hFFFF00, 24'h000000, 24'hFFFF00, 1'b1);
    send(24'h000001, 24'h000000, 24'h7FFFFF, 16'd0, 16'd0, 16'd1, 16'd0);
    expect_first("ovf");
    tile("ovf_t0", 16'd0, 16'd0, 24'h7FFFFF, 24'h800000, 24'h7FFFFF, 24'h800000, 1'b1);

    // Degenerate box
    send(24'h000001, 24'h000000, 24'h000000, 16'd5, 16'd0, 16'd4, 16'd0);
    @(negedge clk);
    check("degen_t1_valid", 32'(out_valid), 32'd0);
    check("degen_t1_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    check("degen_t2_valid", 32'(out_valid), 32'd0);
    check("degen_t2_ready", 32'(in_ready), 32'd1);

    // Box at the top of the coordinate range
    send(24'h000001, 24'h000000, 24'h000000, 16'hFFFE, 16'hFFFF, 16'hFFFF, 16'hFFFF);
    expect_first("edge");
    tile("edge_t0", 16'hFFFE, 16'hFFFF, 24'h00FFFE, 24'h00FFFF, 24'h00FFFE, 24'h00FFFF, 1'b1);
    expect_idle("edge");

    // Asynchronous reset mid-EMIT
    out_ready = 1'b0;
    send(24'h000100, 24'h000200, 24'h000000, 16'd0, 16'd0, 16'd3, 16'd1);
    expect_first("arst");
    #2 rst = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready", 32'(in_ready), 32'd0);
    check("arst_z", 32'(out_z), 32'd0);
    check("arst_x", 32'(out_x), 32'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    expect_idle("arst_rel");
    send(24'h000100, 24'h000200, 24'h000000, 16'd0, 16'd0, 16'd3, 16'd1);
    expect_first("arst2");
    tile("arst2_t0", 16'd0, 16'd0, 24'h000, 24'h100, 24'h200, 24'h300, 1'b0);
    tile("arst2_t1", 16'd2, 16'd0, 24'h200, 24'h300, 24'h400, 24'h500, 1'b1);
    expect_idle("arst2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
